lmg_move_packer: RTL and testbench

- Producer end of the legal-move-generator output FIFO interface.
- Accepts single 18-bit moves from the move-generation datapath and packs 8 per 152-bit word.
- Pads each final partial word with invalid slots and buffers words in an internal FIFO.
- Presents fifo_out / rden / fifo_empty / done to the control block, which pops words and unpacks slots into block RAM.

---
 rtl/lmg_pkg.sv | 29 ++
 rtl/lmg_word_fifo.sv | 62 ++++++
 rtl/lmg_move_packer.sv | 126 ++++++++++++
 tb/tb_lmg_move_packer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lmg_pkg.sv
// Shared types and constants for the legal-move-generator output packer.
// Optional build macro: LMG_MOVE_COUNT_EN (adds move_count output on the top).
package lmg_pkg;

  localparam int unsigned SLOT_W      = 19;
  localparam int unsigned SLOTS       = 8;
  localparam int unsigned WORD_W      = SLOT_W * SLOTS;  // 152
  localparam int unsigned MOVE_W      = 18;
  localparam int unsigned INVALID_OFS = 18;

  typedef logic [SLOT_W-1:0]             slot_t;
  typedef logic [SLOTS-1:0][SLOT_W-1:0]  word_t;

  localparam slot_t EMPTY_SLOT = 19'h40000;
  localparam word_t EMPTY_WORD = {SLOTS{EMPTY_SLOT}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } state_t;

  // A slot carrying a real move: invalid flag clear.
  function automatic slot_t mkSlot(input logic [MOVE_W-1:0] mv);
    return {1'b0, mv};
  endfunction

endpackage

// File: rtl/lmg_word_fifo.sv
// Word FIFO between the move packer and the control block.
// Registered read port; an empty pop returns the all-invalid word.
module lmg_word_fifo
  import lmg_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  clear,
  input  logic  push,
  input  word_t pushData,
  input  logic  pop,
  output word_t dout,
  output logic  full,
  output logic  empty
);

  localparam logic [ADDR_W:0] PTR_ONE = 1;

  word_t             mem [DEPTH];
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic              doPush;
  logic              doPop;

  assign empty  = (wptr == rptr);
  assign full   = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                  (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign doPush = push && !full && !clear;
  assign doPop  = pop && !empty;

  // Storage array; no reset needed, pointers define validity.
  always_ff @(posedge clk) begin
    if (doPush) mem[wptr[ADDR_W-1:0]] <= pushData;
  end

  // Pointers and registered read word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      dout <= EMPTY_WORD;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
      dout <= EMPTY_WORD;
    end else begin
      if (doPush) wptr <= wptr + PTR_ONE;
      if (pop) begin
        if (doPop) begin
          dout <= mem[rptr[ADDR_W-1:0]];
          rptr <= rptr + PTR_ONE;
        end else begin
          dout <= EMPTY_WORD;
        end
      end
    end
  end

endmodule

// File: rtl/lmg_move_packer.sv
// Packs 18-bit moves eight to a word, pads the last partial word with
// invalid slots and buffers words for the control block.
// Optional build macro: LMG_MOVE_COUNT_EN (saturating accepted-move counter).
module lmg_move_packer
  import lmg_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              move_valid,
  input  logic [MOVE_W-1:0] move_data,
  output logic              move_ready,
  input  logic              gen_done,
  input  logic              rden,
  output logic [WORD_W-1:0] fifo_out,
  output logic              fifo_empty,
  output logic              done
`ifdef LMG_MOVE_COUNT_EN
  ,
  output logic [9:0]        move_count
`endif
);

  state_t      state;
  state_t      nextState;
  word_t       slots;
  logic [2:0]  slotCnt;
  logic [2:0]  cntAfter;
  logic        accept;
  logic        push;
  word_t       pushWord;
  word_t       fifoWord;
  logic        fifoFull;

  // A move presented alongside start is dropped: start wins.
  assign accept   = (state == COLLECT) && move_valid && move_ready && !start;
  assign cntAfter = accept ? (slotCnt + 3'd1) : slotCnt;
  assign fifo_out = fifoWord;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state selection; start restarts from any state.
  always_comb begin
    nextState = state;
    if (start) begin
      nextState = COLLECT;
    end else begin
      unique case (state)
        COLLECT: if (gen_done) nextState = (cntAfter != 3'd0) ? FLUSH : DONE;
        FLUSH:   if (!fifoFull) nextState = DONE;
        default: ;
      endcase
    end
  end

  // Handshake, done flag and FIFO write selection.
  always_comb begin
    move_ready = 1'b0;
    done       = 1'b0;
    push       = 1'b0;
    pushWord   = slots;
    unique case (state)
      COLLECT: begin
        move_ready = !(slotCnt == 3'd7 && fifoFull);
        if (accept && slotCnt == 3'd7) begin
          push                 = 1'b1;
          pushWord[SLOTS-1]    = mkSlot(move_data);
        end
      end
      FLUSH:   push = !fifoFull && !start;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Slot register: unfilled slots always hold the invalid pattern, so the
  // flush word is simply the register contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slots   <= EMPTY_WORD;
      slotCnt <= '0;
    end else if (start) begin
      slots   <= EMPTY_WORD;
      slotCnt <= '0;
    end else if (accept) begin
      if (slotCnt == 3'd7) slots <= EMPTY_WORD;
      else                 slots[slotCnt] <= mkSlot(move_data);
      slotCnt <= slotCnt + 3'd1;
    end else if (state == FLUSH && !fifoFull) begin
      slots   <= EMPTY_WORD;
      slotCnt <= '0;
    end
  end

`ifdef LMG_MOVE_COUNT_EN
  // Saturating count of accepted moves for the current board.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             move_count <= '0;
    else if (start)                        move_count <= '0;
    else if (accept && move_count != '1)   move_count <= move_count + 10'd1;
  end
`endif

  lmg_word_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W)
  ) uFifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (start),
    .push     (push),
    .pushData (pushWord),
    .pop      (rden),
    .dout     (fifoWord),
    .full     (fifoFull),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_lmg_move_packer.sv
// Scoreboard bench for lmg_move_packer: stimulus pushes expected words,
// a monitor compares each popped word against the queue head.
module tb_lmg_move_packer;
  import lmg_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              move_valid;
  logic [MOVE_W-1:0] move_data;
  logic              move_ready;
  logic              gen_done;
  logic              rden;
  logic [WORD_W-1:0] fifo_out;
  logic              fifo_empty;
  logic              done;
`ifdef LMG_MOVE_COUNT_EN
  logic [9:0]        move_count;
`endif

  int    total = 0;
  int    bad   = 0;
  word_t sbq[$];
  word_t modelWord;
  int    modelCnt;
  logic  popSeen;

  always #5 clk = ~clk;

  lmg_move_packer #(
    .FIFO_DEPTH (16),
    .ADDR_W     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .move_valid (move_valid),
    .move_data  (move_data),
    .move_ready (move_ready),
    .gen_done   (gen_done),
    .rden       (rden),
    .fifo_out   (fifo_out),
    .fifo_empty (fifo_empty),
    .done       (done)
`ifdef LMG_MOVE_COUNT_EN
    ,
    .move_count (move_count)
`endif
  );

  task automatic chk(input string name, input logic [WORD_W-1:0] got,
                     input logic [WORD_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Monitor: any pop of a non-empty FIFO must yield the scoreboard head.
  always begin
    @(posedge clk);
    popSeen = rden && !fifo_empty && !reset && !start;
    #1;
    if (popSeen) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got %h want none", fifo_out);
      end else begin
        word_t exp;
        exp = sbq.pop_front();
        if (fifo_out !== exp) begin
          bad++;
          $display("FAIL pop_word: got %h want %h", fifo_out, exp);
        end
      end
    end
  end

  task automatic modelClear();
    modelWord = EMPTY_WORD;
    modelCnt  = 0;
  endtask

  task automatic modelAdd(input logic [MOVE_W-1:0] d);
    modelWord[modelCnt] = {1'b0, d};
    modelCnt++;
    if (modelCnt == SLOTS) begin
      sbq.push_back(modelWord);
      modelClear();
    end
  endtask

  task automatic modelFlush();
    if (modelCnt > 0) begin
      sbq.push_back(modelWord);
      modelClear();
    end
  endtask

  // All tasks begin and end just after a falling edge.
  task automatic sendMove(input logic [MOVE_W-1:0] d, input logic gd);
    int unsigned waitc = 0;
    move_valid = 1'b1;
    move_data  = d;
    while (!move_ready && waitc < 300) begin
      @(negedge clk);
      waitc++;
    end
    if (!move_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready=0 want ready=1");
    end
    gen_done = gd;
    @(negedge clk);
    move_valid = 1'b0;
    gen_done   = 1'b0;
    modelAdd(d);
    if (gd) modelFlush();
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sbq.delete();
    modelClear();
  endtask

  task automatic pulseGenDone();
    gen_done = 1'b1;
    @(negedge clk);
    gen_done = 1'b0;
    modelFlush();
  endtask

  task automatic pulseRden();
    rden = 1'b1;
    @(negedge clk);
    rden = 1'b0;
  endtask

  task automatic drain();
    int unsigned c = 0;
    rden = 1'b1;
    while (!(done && fifo_empty) && c < 400) begin
      @(negedge clk);
      c++;
    end
    rden = 1'b0;
    chk("drain_complete", {151'd0, done && fifo_empty}, {151'd0, 1'b1});
    chk("sb_empty", WORD_W'(sbq.size()), '0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; move_valid = 1'b0; move_data = '0;
    gen_done = 1'b0; rden = 1'b0;
    modelClear();
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_ready", {151'd0, move_ready}, '0);
    chk("rst_fifo_out", fifo_out, EMPTY_WORD);
    chk("rst_empty", {151'd0, fifo_empty}, {151'd0, 1'b1});
    chk("rst_done", {151'd0, done}, '0);
    reset = 1'b0;
    @(negedge clk);

    // Full word of 1..8, then gen_done with nothing held
    pulseStart();
    for (int i = 1; i <= 8; i++) sendMove(18'(i), 1'b0);
    chk("t1_latency_empty", {151'd0, fifo_empty}, '0);
    pulseGenDone();
    chk("t1_done", {151'd0, done}, {151'd0, 1'b1});
    drain();
    chk("t1_empty_after", {151'd0, fifo_empty}, {151'd0, 1'b1});
    pulseRden();
    chk("t1_pop_empty", fifo_out, EMPTY_WORD);

    // Three moves, gen_done with the third: padded flush word
    pulseStart();
    sendMove(18'h0A0A0, 1'b0);
    sendMove(18'h0B0B0, 1'b0);
    sendMove(18'h0C0C0, 1'b1);
    chk("t2_flush_not_done", {151'd0, done}, '0);
    @(negedge clk);
    chk("t2_done", {151'd0, done}, {151'd0, 1'b1});
    chk("t2_nonempty", {151'd0, fifo_empty}, '0);
    drain();

    // No moves at all
    pulseStart();
    pulseGenDone();
    chk("t3_done", {151'd0, done}, {151'd0, 1'b1});
    chk("t3_empty", {151'd0, fifo_empty}, {151'd0, 1'b1});
    pulseRden();
    chk("t3_pop_empty", fifo_out, EMPTY_WORD);

    // Fill FIFO, stall on the 8th slot of word 17, resume after one pop
    pulseStart();
    for (int i = 0; i < 135; i++) sendMove(18'h10000 + 18'(i), 1'b0);
    chk("t4_stall", {151'd0, move_ready}, '0);
    pulseRden();
    chk("t4_resume", {151'd0, move_ready}, {151'd0, 1'b1});
    for (int i = 135; i < 140; i++) sendMove(18'h10000 + 18'(i), 1'b0);
    pulseGenDone();
    @(negedge clk);
    chk("t4_flush_held", {151'd0, done}, '0);
    chk("t4_still_full", {151'd0, fifo_empty}, '0);
    drain();

    // Mid-stream restart discards everything buffered
    pulseStart();
    for (int i = 0; i < 20; i++) sendMove(18'h01000 + 18'(i), 1'b0);
    chk("t5_pre_nonempty", {151'd0, fifo_empty}, '0);
    pulseStart();
    chk("t5_empty", {151'd0, fifo_empty}, {151'd0, 1'b1});
    chk("t5_done", {151'd0, done}, '0);
    chk("t5_fifo_out", fifo_out, EMPTY_WORD);
    for (int i = 0; i < 8; i++) sendMove(18'h2A000 + 18'(i), 1'b0);
    pulseGenDone();
    chk("t5_done_after", {151'd0, done}, {151'd0, 1'b1});
    drain();

    // Reset while flushing
    pulseStart();
    sendMove(18'h00111, 1'b0);
    sendMove(18'h00222, 1'b1);
    reset = 1'b1;
    #1;
    chk("t6_ready", {151'd0, move_ready}, '0);
    chk("t6_fifo_out", fifo_out, EMPTY_WORD);
    chk("t6_empty", {151'd0, fifo_empty}, {151'd0, 1'b1});
    chk("t6_done", {151'd0, done}, '0);
    sbq.delete();
    modelClear();
    @(negedge clk);
    chk("t6_done_held", {151'd0, done}, '0);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_done_after", {151'd0, done}, '0);
    chk("t6_empty_after", {151'd0, fifo_empty}, {151'd0, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
